// File: rtl/uart_tx_port_if.sv
// Write handshake between the core's write-back stage and the UART TX port.
//
// Handshake: the master raises uart_wenable for exactly one cycle with the
// word on uart_wdata. The slave answers with a single-cycle uart_wdone once
// the low byte is in its FIFO, either the cycle after the request or later if
// the FIFO was full. The master must not issue another request until it has
// seen uart_wdone for the previous one.
interface uart_tx_port_if;
  logic        uart_wenable;
  logic [31:0] uart_wdata;
  logic        uart_wdone;

  modport master (output uart_wenable, output uart_wdata, input uart_wdone);
  modport slave  (input uart_wenable, input uart_wdata, output uart_wdone);
endinterface

// File: rtl/uart_tx_port.sv
// UART transmit port: queues the low byte of each write request in a small
// FIFO, acknowledges once queued, and serializes queued bytes as 8N1 frames.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit before the stop
// bit, giving 11-bit frames.
module uart_tx_port #(
  parameter int CLK_PER_BIT    = 868,
  parameter int FIFO_DEPTH_LOG = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  uart_tx_port_if.slave        wr,
  output logic                 txd,
  output logic                 busy,
  output logic [2:0]           dbg_state
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG;
  localparam int BW    = $clog2(CLK_PER_BIT);
  localparam logic [BW-1:0]           BAUD_LAST = BW'(CLK_PER_BIT - 1);
  localparam logic [FIFO_DEPTH_LOG:0] CNT_FULL  = (FIFO_DEPTH_LOG + 1)'(DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  // FIFO storage and bookkeeping
  logic [7:0]                mem_q [DEPTH];
  logic [FIFO_DEPTH_LOG-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [FIFO_DEPTH_LOG:0]   cnt_q, cnt_d;
  logic                      full, push, pop;
  logic [7:0]                push_byte;

  // Request path: a byte parked while the FIFO is full
  logic       pend_q, pend_d;
  logic [7:0] pend_byte_q, pend_byte_d;
  logic       done_q, done_d;

  // Serializer
  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          baud_end;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  // Upper request bits are never transmitted.
  logic unused_wdata;
  assign unused_wdata = ^wr.uart_wdata[31:8];

  assign full     = (cnt_q == CNT_FULL);
  assign baud_end = (baud_q == BAUD_LAST);

  // Request handling: push straight in, or park one byte while full. A new
  // request while a byte is parked is a protocol violation and is dropped.
  always_comb begin
    pend_d      = pend_q;
    pend_byte_d = pend_byte_q;
    done_d      = 1'b0;
    push        = 1'b0;
    push_byte   = wr.uart_wdata[7:0];
    if (pend_q) begin
      if (!full) begin
        push      = 1'b1;
        push_byte = pend_byte_q;
        pend_d    = 1'b0;
        done_d    = 1'b1;
      end
    end else if (wr.uart_wenable) begin
      if (!full) begin
        push   = 1'b1;
        done_d = 1'b1;
      end else begin
        pend_d      = 1'b1;
        pend_byte_d = wr.uart_wdata[7:0];
      end
    end
  end

  // FIFO pointer and occupancy update
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Frame sequencer; txd_d is the line value for the state being entered.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (cnt_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rptr_q];
`ifdef UART_TX_PARITY_EN
          par_d   = ^mem_q[rptr_q];
`endif
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_START;
          txd_d   = 1'b0;
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = S_DATA;
          txd_d   = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            txd_d   = par_q;
`else
            state_d = S_STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = S_STOP;
          txd_d   = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = S_IDLE;
          txd_d   = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  // FIFO storage write; contents need no reset since count guards reads.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= push_byte;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      pend_byte_q <= '0;
      done_q      <= 1'b0;
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      txd_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_byte_q <= pend_byte_d;
      done_q      <= done_d;
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      txd_q       <= txd_d;
`ifdef UART_TX_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  assign wr.uart_wdone = done_q;
  assign txd           = txd_q;
  assign busy          = pend_q | (cnt_q != '0) | (state_q != S_IDLE);
  assign dbg_state     = state_q;

endmodule

// File: doc/uart_tx_port.md
Name: uart_tx_port

Overview:
- Device end of the core's UART write handshake (uart_wenable / uart_wdata / uart_wdone).
- Accepts one-word write requests from the write-back stage and queues the low byte in a small FIFO.
- Acknowledges each request with a one-cycle done pulse once the byte is queued, not when it is sent.
- Serializes queued bytes onto txd as 8N1 frames at a fixed clock-per-bit rate.

Parameters:
- CLK_PER_BIT, 868: clocks per serial bit; legal range ≥2 (868 = 100 MHz / 115200).
- FIFO_DEPTH_LOG, 4: FIFO depth is 2**FIFO_DEPTH_LOG bytes.

Ports:
- clk  input  1  clock.
- rstn  input  1  synchronous active-low reset.
- uart_wenable  input  1  one-cycle write request pulse.
- uart_wdata  input  32  request word; only bits [7:0] are transmitted.
- uart_wdone  output  1  one-cycle acknowledge; the byte is queued.
- txd  output  1  serial line; idles high.
- busy  output  1  high when a request is pending, the FIFO is non-empty, or the FSM is not in IDLE.

Behaviour:
- Interface: reset is rstn, synchronous, active-low; clock is clk.
- Reset values:
  - txd=1, uart_wdone=0.
  - FIFO empty; read/write pointers and count = 0.
  - pending=0, FSM=IDLE, baud and bit counters = 0.
  - busy=0 in the cycle after the reset edge.
- Reset mid-frame aborts the frame; txd is 1 after the reset edge. Queued and pending bytes are discarded and no done pulse is issued for a pending request.
- Request path:
  - uart_wenable sampled high with pending=0 and FIFO not full: push uart_wdata[7:0] at that edge. uart_wdone=1 for exactly the next cycle.
  - uart_wenable sampled high with FIFO full: latch the byte, set pending=1, no done.
  - pending=1 and FIFO not full: push the latched byte, clear pending, drive uart_wdone=1 for one cycle.
  - "Full" is the registered count == depth before the edge. A pop and a pending push at the same edge do not combine: the push happens one edge later.
  - uart_wenable while pending=1 violates the protocol: ignored, with no extra done and no overwrite.
- FIFO:
  - Circular buffer with count width FIFO_DEPTH_LOG+1; pointers wrap modulo depth.
  - A push and a pop at the same edge (not full, not empty) leave count unchanged.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If the FIFO is non-empty, pop the head into shift_reg, clear baud_cnt and bit_cnt, go to START.
  - START: txd=0 for CLK_PER_BIT cycles, then DATA.
  - DATA: txd=shift_reg[0] for CLK_PER_BIT cycles per bit, shift right, LSB first. After bit_cnt reaches 7, go to STOP.
  - STOP: txd=1 for CLK_PER_BIT cycles, then IDLE.
  - baud_cnt runs 0..CLK_PER_BIT-1 with width $clog2(CLK_PER_BIT); the state advances when baud_cnt==CLK_PER_BIT-1.
  - txd is registered and changes only on state or bit boundaries.
  - Back-to-back frames: exactly one IDLE clock (txd=1) between the end of STOP and the next START.
  - Frame length is 10*CLK_PER_BIT clocks.
- busy is combinational from registers: pending | (count!=0) | (state!=IDLE).

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP.
  - txd = XOR of the 8 data bits (even parity) for CLK_PER_BIT cycles.
  - Frame length is 11*CLK_PER_BIT clocks.
- Undefined: no PARITY state and 10-bit 8N1 frames.

Test Plan:
- Reset check: hold rstn=0 for 3 clocks → txd=1, uart_wdone=0, busy=0 after release; no txd transitions for 50 clocks.
- Single byte, CLK_PER_BIT=4: pulse uart_wenable with 0x000000A5 →
  - uart_wdone high exactly the cycle after the sampling edge;
  - txd emits 0,1,0,1,0,0,1,0,1,1, each held 4 clocks;
  - busy falls after STOP.
- Upper bits ignored: write 0xFFFFFF00 → data bits all 0, frame 0,0,0,0,0,0,0,0,0,1.
- Backpressure, FIFO_DEPTH_LOG=2, CLK_PER_BIT=4: write 0x01..0x06, each issued the cycle after the previous done →
  - writes 1-5 acknowledged within 1 cycle each;
  - write 6's done is delayed until the edge after IDLE pops 0x02;
  - txd carries 0x01..0x06 in order with 1-clock gaps.
- Reset mid-frame: queue 0x55 and 0x33, assert rstn=0 during the DATA bit 3 of the first frame →
  - txd=1 next cycle, busy=0;
  - after release, no further frames are transmitted.
- Parity (UART_TX_PARITY_EN defined, CLK_PER_BIT=4): write 0x07 → txd 0,1,1,1,0,0,0,0,0,1(parity),1(stop); frame length 44 clocks.
